// File: rtl/wb_pkg.sv
// Shared defaults and constants for the write-back buffer slice.
package wb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int DEPTH_DEF  = 4;

    // Occupancy counter needs one extra bit so that "full" and "empty" are distinct.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(DEPTH_DEF);
    localparam int ZERO_REG  = 0;

endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH-entry FIFO with flush; exposes every slot so the parent can search it.
module wb_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push,
    input  logic                           pop,
    input  logic [W-1:0]                   wdata,
    output logic [$clog2(DEPTH):0]         count,
    output logic [$clog2(DEPTH)-1:0]       rd_ptr,
    output logic [W-1:0]                   head,
    output logic [DEPTH-1:0][W-1:0]        entries
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic                    w_push;
    logic                    w_pop;

    // Flush wins over both sides; pop on empty and push on full are dropped here too.
    assign w_push = push && !flush && (r_count != CNT_W'(DEPTH));
    assign w_pop  = pop  && !flush && (r_count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

    assign count   = r_count;
    assign rd_ptr  = r_rd_ptr;
    assign head    = r_mem[r_rd_ptr];
    assign entries = r_mem;

endmodule

// File: rtl/writeback_buffer.sv
// Write-back stage: result select, register-write queue toward the register file,
// and a youngest-match forwarding lookup over the queued writes.
module writeback_buffer
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_ans_alu,
    input  logic [DATA_W-1:0]        in_ans_dm,
    input  logic                     in_mem_sel,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic                     in_we,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic                     rf_ready,
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [CNT_W-1:0]            w_count;
    logic [PTR_W-1:0]            w_rd_ptr;
    logic [ENT_W-1:0]            w_head;
    logic [DEPTH-1:0][ENT_W-1:0] w_entries;
    logic [DATA_W-1:0]           w_result;
    logic                        w_nonempty;
    logic                        w_store;
    logic                        w_pop;
    logic [PTR_W-1:0]            w_idx;
    logic                        w_fwd_hit;
    logic [DATA_W-1:0]           w_fwd_data;

    assign in_ready   = (w_count != CNT_W'(DEPTH)) && !flush;
    assign w_nonempty = (w_count != '0);
    assign w_result   = in_mem_sel ? in_ans_dm : in_ans_alu;

    // Writes to the zero register or non-writing instructions complete the handshake only.
    assign w_store = in_valid && in_ready && in_we && (in_rd != ADDR_W'(ZERO_REG));
    assign w_pop   = w_nonempty && rf_ready;

    wb_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (w_store),
        .pop     (w_pop),
        .wdata   ({in_rd, w_result}),
        .count   (w_count),
        .rd_ptr  (w_rd_ptr),
        .head    (w_head),
        .entries (w_entries)
    );

    assign rf_we    = w_nonempty;
    assign rf_addr  = w_nonempty ? w_head[DATA_W +: ADDR_W] : '0;
    assign rf_wdata = w_nonempty ? w_head[DATA_W-1:0]       : '0;
    assign count    = w_count;

    // Walk from oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int a = 0; a < DEPTH; a++) begin
            w_idx = w_rd_ptr + PTR_W'(a);
            if ((CNT_W'(a) < w_count) &&
                (fwd_addr != ADDR_W'(ZERO_REG)) &&
                (w_entries[w_idx][DATA_W +: ADDR_W] == fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = w_entries[w_idx][DATA_W-1:0];
            end
        end
    end

    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed self-checking bench for writeback_buffer (default parameters).
module tb_writeback_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ans_alu;
    logic [15:0] in_ans_dm;
    logic        in_mem_sel;
    logic [2:0]  in_rd;
    logic        in_we;
    logic        rf_we;
    logic [2:0]  rf_addr;
    logic [15:0] rf_wdata;
    logic        rf_ready;
    logic [2:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    writeback_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ans_alu (in_ans_alu),
        .in_ans_dm  (in_ans_dm),
        .in_mem_sel (in_mem_sel),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .rf_ready   (rf_ready),
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] rd, input logic [15:0] alu,
                         input logic [15:0] dm, input logic sel, input logic we);
        in_valid   = v;
        in_rd      = rd;
        in_ans_alu = alu;
        in_ans_dm  = dm;
        in_mem_sel = sel;
        in_we      = we;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; rf_ready = 1'b0; fwd_addr = 3'd0;
        drive(1'b1, 3'd2, 16'h0002, 16'h0000, 1'b0, 1'b1);
        tick(); tick();
        $display("txn reset held");
        chk("rst_count", count, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fwd_hit", fwd_hit, 0);
        chk("rst_fwd_data", fwd_data, 0);

        // First push after release appears on the head next cycle.
        reset = 1'b1;
        tick();
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        $display("txn push rd=2 data=0002");
        chk("lat_rf_we", rf_we, 1);
        chk("lat_rf_addr", rf_addr, 2);
        chk("lat_rf_wdata", rf_wdata, 16'h0002);
        chk("lat_count", count, 1);
        rf_ready = 1'b1;
        tick();
        chk("lat_pop_count", count, 0);
        chk("lat_pop_rf_we", rf_we, 0);

        // Fill beyond capacity with the register file stalled.
        rf_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 3'(k), 16'hAAA0 + 16'(k), 16'h0, 1'b0, 1'b1);
            #1;
            $display("txn fill push rd=%0d", k);
            chk("fill_in_ready", in_ready, (k <= 4) ? 1 : 0);
            tick();
        end
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        rf_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", in_ready, 0);
        for (int k = 1; k <= 4; k++) begin
            $display("txn drain pop %0d", k);
            chk("drain_addr", rf_addr, k);
            chk("drain_data", rf_wdata, 16'hAAA0 + 16'(k));
            tick();
        end
        chk("drain_count", count, 0);
        chk("drain_rf_we", rf_we, 0);

        // Filtered writes complete the handshake without being stored.
        drive(1'b1, 3'd0, 16'hFFFF, 16'h0, 1'b0, 1'b1);
        #1;
        $display("txn filtered rd=0");
        chk("filt0_in_ready", in_ready, 1);
        tick();
        chk("filt0_count", count, 0);
        chk("filt0_rf_we", rf_we, 0);
        drive(1'b1, 3'd3, 16'h5555, 16'h0, 1'b0, 1'b0);
        $display("txn filtered we=0");
        tick();
        chk("filtwe_count", count, 0);
        chk("filtwe_rf_we", rf_we, 0);

        // Memory result select.
        rf_ready = 1'b0;
        drive(1'b1, 3'd6, 16'hBEEF, 16'h1234, 1'b1, 1'b1);
        $display("txn mem_sel rd=6");
        tick();
        chk("sel_rf_wdata", rf_wdata, 16'h1234);
        chk("sel_rf_addr", rf_addr, 6);

        // Forwarding picks the youngest match.
        drive(1'b1, 3'd4, 16'h0011, 16'h0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 3'd4, 16'h0022, 16'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        fwd_addr = 3'd4;
        #1;
        $display("txn fwd rd=4");
        chk("fwd4_hit", fwd_hit, 1);
        chk("fwd4_data", fwd_data, 16'h0022);
        fwd_addr = 3'd6;
        #1;
        chk("fwd6_data", fwd_data, 16'h1234);
        fwd_addr = 3'd0;
        #1;
        chk("fwd0_hit", fwd_hit, 0);
        chk("fwd0_data", fwd_data, 0);
        fwd_addr = 3'd5;
        #1;
        chk("fwd5_hit", fwd_hit, 0);
        chk("fwd_count", count, 3);
        rf_ready = 1'b1;
        tick(); tick(); tick();
        fwd_addr = 3'd4;
        #1;
        chk("fwd_drained_hit", fwd_hit, 0);
        chk("fwd_drained_count", count, 0);

        // Steady streaming across pointer wrap, then flush with three held.
        rf_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 3'((j % 7) + 1), 16'h0100 + 16'(j), 16'h0, 1'b0, 1'b1);
            tick();
        end
        rf_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'(((i + 3) % 7) + 1), 16'h0103 + 16'(i), 16'h0, 1'b0, 1'b1);
            #1;
            $display("txn stream %0d", i);
            chk("stream_data", rf_wdata, 16'h0100 + 16'(i));
            chk("stream_addr", rf_addr, (i % 7) + 1);
            chk("stream_count", count, 3);
            tick();
        end
        flush = 1'b1;
        drive(1'b1, 3'd5, 16'h7777, 16'h0, 1'b0, 1'b1);
        #1;
        $display("txn flush");
        chk("flush_in_ready", in_ready, 0);
        chk("flush_rf_we", rf_we, 1);
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("post_flush_count", count, 0);
        chk("post_flush_rf_we", rf_we, 0);
        chk("post_flush_wdata", rf_wdata, 0);
        chk("post_flush_in_ready", in_ready, 1);

        // Asynchronous reset mid-cycle clears held state immediately.
        rf_ready = 1'b0;
        drive(1'b1, 3'd3, 16'h0033, 16'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("pre_async_count", count, 1);
        #1;
        reset = 1'b0;
        #1;
        $display("txn async reset");
        chk("async_count", count, 0);
        chk("async_rf_we", rf_we, 0);
        chk("async_fwd_hit", fwd_hit, 0);
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
Parametrised write-back stage for the MIPS pipeline; successor to the fixed 16-bit single-register write block.
- Selects the ALU or data-memory result per instruction.
- Queues register-file writes in a DEPTH-entry buffer with valid/ready handshakes on both sides.
- Offers a forwarding lookup over pending writes.
- Sits between the data-memory stage and the register-file write port.

Parameters:
DATA_W, 16, result/register data width
ADDR_W, 3, register address width (2^ADDR_W registers; register 0 is hard-wired zero)
DEPTH, 4, pending-write buffer entries; power of two, >= 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous discard of all pending writes
in_valid  in  1  memory stage presents a result
in_ready  out  1  buffer can accept this cycle
in_ans_alu  in  DATA_W  ALU result
in_ans_dm  in  DATA_W  data-memory result
in_mem_sel  in  1  1 = write in_ans_dm, 0 = write in_ans_alu
in_rd  in  ADDR_W  destination register
in_we  in  1  instruction writes a register
rf_we  out  1  head entry valid toward register file
rf_addr  out  ADDR_W  head destination
rf_wdata  out  DATA_W  head data
rf_ready  in  1  register-file port accepts head this cycle
fwd_addr  in  ADDR_W  forwarding query register
fwd_hit  out  1  a pending write to fwd_addr exists
fwd_data  out  DATA_W  data of youngest matching pending write
count  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (reset=0, asynchronous): read/write pointers=0, count=0; rf_we=0, rf_addr=0, rf_wdata=0, fwd_hit=0, fwd_data=0. Storage array is not reset.
- in_ready = (count != DEPTH) && !flush. Combinational from registered state only; no path from rf_ready.
- Accept when in_valid && in_ready:
  - If in_we=1 and in_rd!=0: store {in_rd, in_mem_sel ? in_ans_dm : in_ans_alu} at the write pointer, advance the pointer, count+1.
  - If in_we=0 or in_rd==0: handshake completes, nothing stored.
- Head output: rf_we = (count != 0); rf_addr/rf_wdata = head entry, forced to 0 when empty.
- Pop when rf_we && rf_ready: advance the read pointer, count-1.
- Latency: an entry accepted in cycle N is on the rf_* port in cycle N+1 if the buffer was empty; otherwise in FIFO order.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: in_ready=0; a pop that cycle frees a slot for the next cycle only.
- Empty: rf_ready is ignored.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- flush=1: next edge sets pointers=0 and count=0. Flush overrides push and pop that cycle; rf_we may still be 1 during the flush cycle but no pop is counted.
- Forwarding (combinational over stored entries only, not the incoming beat):
  - fwd_hit=1 iff fwd_addr!=0 and some valid entry has rd==fwd_addr.
  - fwd_data = data of the youngest such entry, else 0.
- Reset asserted mid-operation: all state clears immediately; contents are lost.

Decomposition:
- Package wb_pkg: default DATA_W/ADDR_W/DEPTH constants, count-width constant, zero-register constant.
- Sub-module wb_fifo: storage array, pointers, count, push/pop/flush. Generic over entry width ADDR_W+DATA_W.
- Top level: result mux, zero-register/in_we filter, head zeroing, youngest-match forwarding search.

Test Plan:
- Reset low with in_valid=1 -> count=0, rf_we=0, rf_wdata=0, in_ready=1; after release, push rd=2, alu=0x0002, mem_sel=0 -> next cycle rf_we=1, rf_addr=2, rf_wdata=0x0002.
- Hold rf_ready=0 and push 5 writes (rd=1..5, data 0xAAA1..0xAAA5) -> 4 accepted, in_ready=0, count=4. Then rf_ready=1 -> pops in order 0xAAA1..0xAAA4, count reaches 0.
- Writes filtered from the buffer -> push rd=0 data 0xFFFF, and rd=3 with in_we=0 -> both handshake, count stays 0, rf_we never asserted.
- mem_sel=1 with dm=0x1234, alu=0xBEEF, rd=6 -> rf_wdata=0x1234.
- Forwarding with rf_ready=0 -> push rd=4 data 0x0011, then rd=4 data 0x0022. fwd_addr=4 -> fwd_hit=1, fwd_data=0x0022; fwd_addr=0 -> fwd_hit=0.
- Steady push+pop for 10 cycles across pointer wrap, then flush with 3 entries held -> data order preserved, count constant; next cycle count=0, rf_we=0, in_ready low during the flush cycle.
